// File: rtl/beamform_v2_pkg.sv
// Shared sizing constants and the fixed beam steering table for the beamform trigger.
// Delays are in samples; beam 0 is naturally broadside (all delays zero).
package beamform_v2_pkg;
  localparam int NCHAN       = 8;
  localparam int NSAMP       = 8;
  localparam int AGC_BITS    = 5;
  localparam int THRESH_BITS = 18;
  localparam int MAX_DELAY   = 15;
  localparam int MAX_BEAMS   = 48;
  localparam int DELAY_BITS  = 4;
  localparam int HIST_SAMP   = 3 * NSAMP;
  localparam int BSUM_BITS   = 8;
  localparam int SQ_BITS     = 15;

  typedef logic [NCHAN-1:0][DELAY_BITS-1:0] beam_delay_t;

  function automatic logic [MAX_BEAMS-1:0][NCHAN-1:0][DELAY_BITS-1:0] gen_delay_table();
    logic [MAX_BEAMS-1:0][NCHAN-1:0][DELAY_BITS-1:0] t;
    for (int b = 0; b < MAX_BEAMS; b++)
      for (int c = 0; c < NCHAN; c++)
        t[b][c] = DELAY_BITS'((b * c) % (MAX_DELAY + 1));
    return t;
  endfunction

  localparam logic [MAX_BEAMS-1:0][NCHAN-1:0][DELAY_BITS-1:0] BEAM_DELAY = gen_delay_table();
endpackage

// File: rtl/beamform_trigger_v2_beam_power.sv
// One beam: delay-select each channel from the 24-sample history, sum, square,
// and accumulate the eight squares of a word into an 18-bit power (3 register stages).
module beam_power
  import beamform_v2_pkg::*;
#(
  parameter beam_delay_t DELAYS = '0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NCHAN-1:0][HIST_SAMP*AGC_BITS-1:0] hist_i,
  output logic [THRESH_BITS-1:0]                  power_o
);
  logic signed [BSUM_BITS-1:0] sum_d [NSAMP];
  logic signed [BSUM_BITS-1:0] sum_q [NSAMP];
  logic [SQ_BITS-1:0]          sq_d  [NSAMP];
  logic [SQ_BITS-1:0]          sq_q  [NSAMP];
  logic [THRESH_BITS-1:0]      power_d;

  // Current word occupies history samples 16..23; delay d reaches back into older words.
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      sum_d[k] = '0;
      for (int c = 0; c < NCHAN; c++)
        sum_d[k] = sum_d[k] + BSUM_BITS'(signed'(
          hist_i[c][(2*NSAMP + k - int'(DELAYS[c]))*AGC_BITS +: AGC_BITS]));
    end
  end

  // |sum| <= 128, so the square fits 15 bits exactly and the low bits of the product suffice.
  always_comb begin
    for (int k = 0; k < NSAMP; k++)
      sq_d[k] = SQ_BITS'(sum_q[k]) * SQ_BITS'(sum_q[k]);
  end

  always_comb begin
    power_d = '0;
    for (int k = 0; k < NSAMP; k++)
      power_d = power_d + THRESH_BITS'(sq_q[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSAMP; k++) begin
        sum_q[k] <= '0;
        sq_q[k]  <= '0;
      end
      power_o <= '0;
    end else begin
      for (int k = 0; k < NSAMP; k++) begin
        sum_q[k] <= sum_d[k];
        sq_q[k]  <= sq_d[k];
      end
      power_o <= power_d;
    end
  end
endmodule

// File: rtl/beamform_trigger_v2.sv
// Beamformed power trigger: input/history registers, NBEAMS power pipelines, and
// double-buffered (shadow/active) per-beam thresholds for the trigger and subthreshold banks.
module beamform_trigger_v2
  import beamform_v2_pkg::*;
#(
  parameter int    NBEAMS       = 2,
  parameter string ZERO_IS_FAKE = "FALSE"
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NCHAN-1:0][NSAMP*AGC_BITS-1:0] data_i,
  input  logic [2*THRESH_BITS-1:0]             thresh_i,
  input  logic [1:0]                           thresh_wr_i,
  input  logic [1:0]                           thresh_update_i,
  output logic [1:0][NBEAMS-1:0]               trigger_o
);
  localparam bit FAKE0 = (ZERO_IS_FAKE == "TRUE");

  logic [NCHAN-1:0][NSAMP*AGC_BITS-1:0]     data_r, prev1_r, prev2_r;
  logic [NCHAN-1:0][HIST_SAMP*AGC_BITS-1:0] hist;
  logic [NBEAMS-1:0][THRESH_BITS-1:0]       power;
  logic [1:0][NBEAMS-1:0][THRESH_BITS-1:0]  shadow, active;

  always_comb begin
    for (int c = 0; c < NCHAN; c++)
      hist[c] = {data_r[c], prev1_r[c], prev2_r[c]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r  <= '0;
      prev1_r <= '0;
      prev2_r <= '0;
    end else begin
      data_r  <= data_i;
      prev1_r <= data_r;
      prev2_r <= prev1_r;
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    localparam beam_delay_t DLY = (b == 0 && FAKE0) ? '0 : BEAM_DELAY[b];
    beam_power #(.DELAYS(DLY)) u_beam_power (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hist_i  (hist),
      .power_o (power[b])
    );
  end

  // Update samples the pre-shift shadow, so a same-cycle write is only seen by a later update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow <= '1;
      active <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (thresh_update_i[i])
          active[i] <= shadow[i];
        if (thresh_wr_i[i]) begin
          shadow[i][NBEAMS-1] <= thresh_i[i*THRESH_BITS +: THRESH_BITS];
          for (int b = 0; b < NBEAMS - 1; b++)
            shadow[i][b] <= shadow[i][b+1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_o <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < NBEAMS; b++)
          trigger_o[i][b] <= (power[b] > active[i][b]);
    end
  end
endmodule

// File: tb/tb_beamform_trigger_v2.sv
// Directed bench for beamform_trigger_v2 (NBEAMS=2, beam 0 unphased, beam 1 delay c on channel c).
module tb_beamform_trigger_v2;
  import beamform_v2_pkg::*;

  localparam int NB = 2;

  logic                                 clk_i = 1'b0;
  logic                                 rst_i;
  logic [NCHAN-1:0][NSAMP*AGC_BITS-1:0] data_i;
  logic [2*THRESH_BITS-1:0]             thresh_i;
  logic [1:0]                           thresh_wr_i;
  logic [1:0]                           thresh_update_i;
  logic [1:0][NB-1:0]                   trigger_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  beamform_trigger_v2 #(.NBEAMS(NB), .ZERO_IS_FAKE("TRUE")) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .data_i          (data_i),
    .thresh_i        (thresh_i),
    .thresh_wr_i     (thresh_wr_i),
    .thresh_update_i (thresh_update_i),
    .trigger_o       (trigger_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_const(input logic [4:0] v);
    for (int c = 0; c < NCHAN; c++)
      for (int k = 0; k < NSAMP; k++)
        data_i[c][5*k +: 5] = v;
  endtask

  // ch0 = +a0 on even samples, -a0 on odd; ch1 likewise with a1; other channels zero
  task automatic set_alt(input int a0, input int a1);
    data_i = '0;
    for (int k = 0; k < NSAMP; k++) begin
      data_i[0][5*k +: 5] = (k % 2 == 0) ? 5'(a0) : 5'(-a0);
      data_i[1][5*k +: 5] = (k % 2 == 0) ? 5'(a1) : 5'(-a1);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    data_i = '0;
    thresh_i = '0;
    thresh_wr_i = '0;
    thresh_update_i = '0;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic program_bank(input int bank, input logic [17:0] t0, input logic [17:0] t1);
    thresh_i = '0;
    thresh_wr_i[bank] = 1'b1;
    thresh_i[bank*18 +: 18] = t0;
    tick();
    thresh_i[bank*18 +: 18] = t1;
    tick();
    thresh_wr_i = '0;
    thresh_update_i[bank] = 1'b1;
    tick();
    thresh_update_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_const(5'b10000);
    thresh_i = '0;
    thresh_wr_i = '0;
    thresh_update_i = '0;
    tick();
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_first_edge: got %b expected %b", trigger_o, 4'b0000);
    end
    tick(2);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", trigger_o, 4'b0000);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_max_power();
    do_reset();
    set_const(5'b10000);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (trigger_o !== 4'b0000) begin
        errors++;
        $display("FAIL max_power_cycle%0d: got %b expected %b", i, trigger_o, 4'b0000);
      end
    end
  endtask

  task automatic test_latency_threshold();
    do_reset();
    program_bank(0, 18'd511, 18'd511);
    tick(6);
    set_const(5'd1);
    tick(4);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL latency_before: got %b expected %b", trigger_o, 4'b0000);
    end
    tick();
    checks++;
    if (trigger_o !== 4'b0001) begin
      errors++;
      $display("FAIL latency_beam0: got %b expected %b", trigger_o, 4'b0001);
    end
    tick();
    checks++;
    if (trigger_o !== 4'b0011) begin
      errors++;
      $display("FAIL latency_beam1_full: got %b expected %b", trigger_o, 4'b0011);
    end
    program_bank(1, 18'd0, 18'd0);
    checks++;
    if (trigger_o !== 4'b0011) begin
      errors++;
      $display("FAIL subthr_update_edge: got %b expected %b", trigger_o, 4'b0011);
    end
    tick();
    checks++;
    if (trigger_o !== 4'b1111) begin
      errors++;
      $display("FAIL subthr_after_update: got %b expected %b", trigger_o, 4'b1111);
    end
    program_bank(0, 18'd512, 18'd512);
    tick();
    checks++;
    if (trigger_o !== 4'b1100) begin
      errors++;
      $display("FAIL thresh_equal_512: got %b expected %b", trigger_o, 4'b1100);
    end
  endtask

  task automatic test_shift_order();
    do_reset();
    program_bank(0, 18'd100, 18'd200);
    set_alt(2, 2);
    tick(7);
    checks++;
    if (trigger_o !== 4'b0001) begin
      errors++;
      $display("FAIL order_beam0_128: got %b expected %b", trigger_o, 4'b0001);
    end
    set_alt(2, -2);
    tick(7);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL order_beam1_128: got %b expected %b", trigger_o, 4'b0000);
    end
    set_alt(3, -3);
    tick(7);
    checks++;
    if (trigger_o !== 4'b0010) begin
      errors++;
      $display("FAIL order_beam1_288: got %b expected %b", trigger_o, 4'b0010);
    end
  endtask

  task automatic run_impulse(input int c, input int j, input logic [3:0] exp5, input logic [3:0] exp6);
    data_i = '0;
    data_i[c][5*j +: 5] = 5'd15;
    tick();
    data_i = '0;
    tick(3);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL impulse_c%0d_j%0d_early: got %b expected %b", c, j, trigger_o, 4'b0000);
    end
    tick();
    checks++;
    if (trigger_o !== exp5) begin
      errors++;
      $display("FAIL impulse_c%0d_j%0d_word0: got %b expected %b", c, j, trigger_o, exp5);
    end
    tick();
    checks++;
    if (trigger_o !== exp6) begin
      errors++;
      $display("FAIL impulse_c%0d_j%0d_word1: got %b expected %b", c, j, trigger_o, exp6);
    end
    tick();
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL impulse_c%0d_j%0d_after: got %b expected %b", c, j, trigger_o, 4'b0000);
    end
    tick(2);
  endtask

  task automatic test_impulse();
    do_reset();
    program_bank(0, 18'd0, 18'd0);
    program_bank(1, 18'd0, 18'd0);
    tick(6);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL impulse_idle: got %b expected %b", trigger_o, 4'b0000);
    end
    run_impulse(3, 6, 4'b0101, 4'b1010);
    run_impulse(5, 1, 4'b1111, 4'b0000);
    run_impulse(7, 2, 4'b0101, 4'b1010);
    run_impulse(0, 7, 4'b1111, 4'b0000);
  endtask

  task automatic test_wr_update_same_cycle();
    do_reset();
    program_bank(0, 18'd511, 18'd511);
    thresh_i = '0;
    thresh_i[17:0] = 18'd1000;
    thresh_wr_i[0] = 1'b1;
    thresh_update_i[0] = 1'b1;
    tick();
    thresh_wr_i = '0;
    thresh_update_i = '0;
    set_const(5'd1);
    tick(7);
    checks++;
    if (trigger_o !== 4'b0011) begin
      errors++;
      $display("FAIL same_cycle_old_shadow: got %b expected %b", trigger_o, 4'b0011);
    end
    thresh_update_i[0] = 1'b1;
    tick();
    thresh_update_i = '0;
    tick();
    checks++;
    if (trigger_o !== 4'b0001) begin
      errors++;
      $display("FAIL same_cycle_later_update: got %b expected %b", trigger_o, 4'b0001);
    end
  endtask

  task automatic test_reset_midstream();
    rst_i = 1'b1;
    tick();
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL midstream_reset_edge: got %b expected %b", trigger_o, 4'b0000);
    end
    rst_i = 1'b0;
    tick(8);
    checks++;
    if (trigger_o !== 4'b0000) begin
      errors++;
      $display("FAIL midstream_thresh_restored: got %b expected %b", trigger_o, 4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_max_power();
    test_latency_threshold();
    test_shift_order();
    test_impulse();
    test_wr_update_same_cycle();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
